// File: rtl/gray_pkg.sv
// gray_pkg: shared types and helpers for the Gray count source (checker enabled by GRAY_CHECK_EN)
package gray_pkg;

   typedef enum logic {IDLE, OFFER} state_t;

   function automatic logic [31:0] bin2gray(input logic [31:0] x);
      return x ^ (x >> 1);
   endfunction

   function automatic int xor_pop(input logic [31:0] a, input logic [31:0] b);
      return $countones(a ^ b);
   endfunction

endpackage

// File: rtl/gray_counter_src_if.sv
// gray_counter_src_if: control inputs and Gray/binary code offer with valid/ready handshake
interface gray_counter_src_if #(parameter int WIDTH = 3);

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] bin_q;
   logic             tc;
   logic             gray_err;

   modport master (
      input  en, up_dn, load, load_bin, out_ready,
      output out_valid, gray_q, bin_q, tc, gray_err
   );

   modport slave (
      output en, up_dn, load, load_bin, out_ready,
      input  out_valid, gray_q, bin_q, tc, gray_err
   );

endinterface

// File: rtl/bin2gray_conv.sv
// bin2gray_conv: combinational binary-to-Gray converter
module bin2gray_conv #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_src.sv
// gray_counter_src: up/down counter offering registered Gray codes over valid/ready; define GRAY_CHECK_EN for the sticky one-bit-step checker
module gray_counter_src
   import gray_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int RESET_VAL = 0
) (
   input logic              clk,
   input logic              rst,
   gray_counter_src_if.master bus
);

   localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(RESET_VAL));

   state_t           state, state_nxt;
   logic [WIDTH-1:0] bin_nxt, gray_nxt;
   logic             xfer, step, wrap;

   assign bus.out_valid = (state == OFFER);

   // Next count and next state: load beats any step, a step needs an accepted offer with en
   always_comb begin
      xfer      = bus.out_valid && bus.out_ready;
      step      = xfer && bus.en && !bus.load;
      wrap      = step && (bus.up_dn ? &bus.bin_q : ~|bus.bin_q);
      bin_nxt   = bus.load ? bus.load_bin
                : step     ? (bus.up_dn ? bus.bin_q + 1'b1 : bus.bin_q - 1'b1)
                :            bus.bin_q;
      state_nxt = bus.load       ? OFFER
                : (state == IDLE) ? (bus.en ? OFFER : IDLE)
                : (xfer && !bus.en) ? IDLE : OFFER;
   end

   bin2gray_conv #(.WIDTH(WIDTH)) u_conv (
      .bin  (bin_nxt),
      .gray (gray_nxt)
   );

   // Handshake state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Binary and Gray registers update together so the Gray output never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.bin_q  <= RST_BIN;
         bus.gray_q <= RST_GRAY;
         bus.tc     <= 1'b0;
      end else begin
         bus.bin_q  <= bin_nxt;
         bus.gray_q <= gray_nxt;
         bus.tc     <= wrap;
      end
   end

`ifdef GRAY_CHECK_EN
   // Sticky flag: any counting step must flip exactly one Gray bit
   always_ff @(posedge clk) begin
      if (rst)                                                   bus.gray_err <= 1'b0;
      else if (step && xor_pop(32'(bus.gray_q), 32'(gray_nxt)) != 1) bus.gray_err <= 1'b1;
   end
`else
   assign bus.gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_src.sv
// tb_gray_counter_src: directed vector table plus an up-sweep sequence for gray_counter_src (WIDTH=3)
module tb_gray_counter_src;

   typedef struct {
      logic       rst, en, up, ld;
      logic [2:0] lb;
      logic       rdy;
      logic       v;
      logic [2:0] b, g;
      logic       tc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vt[$];

   gray_counter_src_if #(.WIDTH(3)) bus ();

   gray_counter_src #(.WIDTH(3), .RESET_VAL(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, en, up, ld, input logic [2:0] lb, input logic rdy,
                      input logic v, input logic [2:0] b, g, input logic tc);
      vec_t x;
      x.rst = r; x.en = en; x.up = up; x.ld = ld; x.lb = lb; x.rdy = rdy;
      x.v = v; x.b = b; x.g = g; x.tc = tc;
      vt.push_back(x);
   endtask

   task automatic drive(input logic r, en, up, ld, input logic [2:0] lb, input logic rdy);
      rst = r; bus.en = en; bus.up_dn = up; bus.load = ld; bus.load_bin = lb; bus.out_ready = rdy;
   endtask

   logic [2:0] exp_seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
   logic [2:0] got [9];
   logic       got_tc [9];

   initial begin
      int n;
      drive(1, 0, 1, 0, 3'd0, 0);
      //   rst en up ld lb    rdy  v  bin   gray  tc
      add(1, 1, 1, 1, 3'd5, 1,   0, 3'd0, 3'b000, 0);
      add(1, 1, 1, 1, 3'd5, 1,   0, 3'd0, 3'b000, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd0, 3'b000, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd1, 3'b001, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 0, 3'd0, 0,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 0, 3'd0, 0,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 0, 3'd0, 0,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd3, 3'b010, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd4, 3'b110, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd5, 3'b111, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd6, 3'b101, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd7, 3'b100, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd0, 3'b000, 1);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd1, 3'b001, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 0, 3'd0, 0,   1, 3'd2, 3'b011, 0);
      add(0, 1, 1, 1, 3'd5, 0,   1, 3'd5, 3'b111, 0);
      add(0, 1, 1, 0, 3'd0, 0,   1, 3'd5, 3'b111, 0);
      add(0, 0, 1, 0, 3'd0, 1,   0, 3'd5, 3'b111, 0);
      add(0, 0, 1, 0, 3'd0, 1,   0, 3'd5, 3'b111, 0);
      add(1, 1, 1, 1, 3'd3, 1,   0, 3'd0, 3'b000, 0);
      add(0, 1, 0, 0, 3'd0, 1,   1, 3'd0, 3'b000, 0);
      add(0, 1, 0, 0, 3'd0, 1,   1, 3'd7, 3'b100, 1);
      add(0, 1, 0, 0, 3'd0, 1,   1, 3'd6, 3'b101, 0);
      add(0, 1, 0, 0, 3'd0, 1,   1, 3'd5, 3'b111, 0);
      add(0, 1, 1, 0, 3'd0, 1,   1, 3'd6, 3'b101, 0);
      add(0, 1, 1, 1, 3'd1, 1,   1, 3'd1, 3'b001, 0);
      add(0, 0, 1, 0, 3'd0, 1,   0, 3'd1, 3'b001, 0);
      add(0, 0, 1, 1, 3'd7, 0,   1, 3'd7, 3'b100, 0);
      add(0, 0, 1, 0, 3'd0, 0,   1, 3'd7, 3'b100, 0);
      add(0, 1, 1, 1, 3'd2, 1,   1, 3'd2, 3'b011, 0);
      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].en, vt[i].up, vt[i].ld, vt[i].lb, vt[i].rdy);
         tick();
         chk("out_valid", i, 32'(bus.out_valid), 32'(vt[i].v));
         chk("bin_q", i, 32'(bus.bin_q), 32'(vt[i].b));
         chk("gray_q", i, 32'(bus.gray_q), 32'(vt[i].g));
         chk("tc", i, 32'(bus.tc), 32'(vt[i].tc));
         chk("gray_err", i, 32'(bus.gray_err), 32'd0);
      end
      drive(1, 0, 1, 0, 3'd0, 1);
      tick();
      drive(0, 1, 1, 0, 3'd0, 1);
      n = 0;
      for (int c = 0; c < 30 && n < 9; c++) begin
         tick();
         if (bus.out_valid && bus.out_ready) begin
            got[n] = bus.gray_q;
            got_tc[n] = bus.tc;
            n++;
         end
      end
      chk("sweep_count", 0, 32'(n), 32'd9);
      for (int k = 0; k < n; k++) begin
         chk("sweep_gray", k, 32'(got[k]), 32'(exp_seq[k]));
         chk("sweep_tc", k, 32'(got_tc[k]), 32'(k == 8));
         if (k > 0) chk("sweep_onebit", k, 32'($countones(got[k] ^ got[k-1])), 32'd1);
      end
      chk("sweep_err", 0, 32'(bus.gray_err), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
